// File: rtl/hypercpu_alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// HyperCPU sequenced ALU wrapper.
package hypercpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_PASS = 4'h9;
  localparam logic [3:0] OP_RSVA = 4'hA;
  localparam logic [3:0] OP_RSVB = 4'hB;
  localparam logic [3:0] OP_ADD  = 4'hC;
  localparam logic [3:0] OP_SUB  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_DIV  = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSVA) || (op == OP_RSVB);
  endfunction

endpackage

// File: rtl/hypercpu_alu_seq_if.sv
// Request, response and external-ALU signal bundle of the sequenced ALU.
interface hypercpu_alu_seq_if;
  import hypercpu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [3:0]        req_op;
  logic [3:0]        req_tag;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_r;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_r;
  logic [3:0]        rsp_tag;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, alu_r, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_r, rsp_tag, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, alu_r, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_r, rsp_tag, rsp_err
  );
endinterface

// File: rtl/hypercpu_alu_seq.sv
// Sequencer around the external combinational ALU: accepts one request,
// holds operands on the ALU for a fixed number of cycles (longer for
// mul/div), then presents the result with tag and error flag.
module hypercpu_alu_seq
  import hypercpu_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  hypercpu_alu_seq_if.slave  bus
);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic              capture;

  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] opb_p0;
  logic [3:0]        op_p0;
  logic [3:0]        tag_p0;

  logic [DATA_W-1:0] res_r;
  logic              res_err;

  logic [DATA_W-1:0] r_p1;
  logic [3:0]        tag_p1;
  logic              err_p1;

  assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign capture       = (state == ST_EXEC) && (wait_cnt == 4'd0);

  assign bus.alu_a     = opa_p0;
  assign bus.alu_b     = opb_p0;
  assign bus.alu_op    = op_p0;

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_r     = r_p1;
  assign bus.rsp_tag   = tag_p1;
  assign bus.rsp_err   = err_p1;

  // Result override: reserved ops and divide-by-zero bypass the ALU output.
  always_comb begin
    res_r   = bus.alu_r;
    res_err = 1'b0;
    if (is_reserved(op_p0)) begin
      res_r   = '0;
      res_err = 1'b1;
    end else if ((op_p0 == OP_DIV) && (opb_p0 == '0)) begin
      res_r   = '1;
      res_err = 1'b1;
    end
  end

  // Control FSM and mul/div wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else if (accept) begin
      state    <= ST_EXEC;
      wait_cnt <= is_muldiv(bus.req_op) ? 4'(MULDIV_WAIT) : 4'd0;
    end else begin
      case (state)
        ST_EXEC: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: operand registers, held on the ALU until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p0 <= '0;
      opb_p0 <= '0;
      op_p0  <= 4'd0;
      tag_p0 <= 4'd0;
    end else if (accept) begin
      opa_p0 <= bus.req_a;
      opb_p0 <= bus.req_b;
      op_p0  <= bus.req_op;
      tag_p0 <= bus.req_tag;
    end
  end

  // ---- stage p1: response registers, frozen while the response is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1   <= '0;
      tag_p1 <= 4'd0;
      err_p1 <= 1'b0;
    end else if (capture) begin
      r_p1   <= res_r;
      tag_p1 <= tag_p0;
      err_p1 <= res_err;
    end
  end

endmodule

// File: tb/tb_hypercpu_alu_seq.sv
// Self-checking bench for hypercpu_alu_seq with a behavioural ALU stand-in
// and a transaction-level reference model.
module tb_hypercpu_alu_seq;
  import hypercpu_pkg::*;

  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hypercpu_alu_seq_if bus();

  hypercpu_alu_seq #(.MULDIV_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in combinational ALU; divide-by-zero returns 0 so the override is visible.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[4:0];
      OP_SHR:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      OP_PASS: return b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 32'd0) ? 32'd0 : a / b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  // Expected response of one transaction.
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           output logic [31:0] r, output logic err, output int lat);
    lat = (op == 4'hE || op == 4'hF) ? 1 + MW : 1;
    if (op == 4'hA || op == 4'hB) begin
      r = 32'd0; err = 1'b1;
    end else if (op == 4'hF && b == 32'd0) begin
      r = 32'hFFFF_FFFF; err = 1'b1;
    end else begin
      r = alu_fn(a, b, op); err = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [3:0] tag);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
  endtask

  // Single isolated transaction; called at a negedge with rsp_ready low.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [3:0] tag);
    logic [31:0] er;
    logic        ee;
    int          el;
    int          j;
    ref_model(a, b, op, er, ee, el);
    check({name, "_rdy"}, 32'(bus.req_ready), 32'd1);
    drive_req(a, b, op, tag);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({name, "_alu_a"}, bus.alu_a, a);
    check({name, "_alu_op"}, 32'(bus.alu_op), 32'(op));
    j = 0;
    while (!bus.rsp_valid && j < 60) begin
      @(negedge clk);
      j++;
    end
    check({name, "_lat"}, 32'(j), 32'(el));
    check({name, "_r"}, bus.rsp_r, er);
    check({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
    check({name, "_err"}, 32'(bus.rsp_err), 32'(ee));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({name, "_drop"}, 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  // Randomised stream with random response backpressure; in-order scoreboard.
  task automatic run_stream(input int n);
    logic [31:0] q_r[$];
    logic        q_e[$];
    logic [3:0]  q_t[$];
    int          sent;
    int          got;
    int          cyc;
    logic        fire_req;
    logic        fire_rsp;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] er;
    logic        ee;
    int          el;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 3000) begin
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      if (!bus.req_valid && sent < n && $urandom_range(0, 3) != 0) begin
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        b  = $urandom;
        if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
        if (op == OP_DIV && b != 32'd0) b = b >> $urandom_range(0, 31);
        drive_req(a, b, op, 4'(sent));
      end
      #1;
      fire_req = bus.req_valid && bus.req_ready;
      fire_rsp = bus.rsp_valid && bus.rsp_ready;
      if (fire_rsp) begin
        if (q_r.size() == 0) begin
          check("stream_spurious", 32'd1, 32'd0);
        end else begin
          check("stream_tag", 32'(bus.rsp_tag), 32'(q_t.pop_front()));
          check("stream_r", bus.rsp_r, q_r.pop_front());
          check("stream_err", 32'(bus.rsp_err), 32'(q_e.pop_front()));
        end
        got++;
      end
      if (fire_req) begin
        ref_model(bus.req_a, bus.req_b, bus.req_op, er, ee, el);
        q_r.push_back(er);
        q_e.push_back(ee);
        q_t.push_back(bus.req_tag);
        sent++;
      end
      @(negedge clk);
      cyc++;
      if (fire_req) bus.req_valid = 1'b0;
    end
    check("stream_count", 32'(got), 32'(n));
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 4'd0;
    bus.req_tag   = 4'd0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_r", bus.rsp_r, 32'd0);
    check("rst_tag", 32'(bus.rsp_tag), 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Directed transactions
    run_one("add", 32'd5, 32'd7, OP_ADD, 4'd3);
    run_one("div", 32'd100, 32'd7, OP_DIV, 4'd4);
    run_one("div0", 32'd100, 32'd0, OP_DIV, 4'd5);
    run_one("rsvb", 32'd1, 32'd1, OP_RSVB, 4'd6);
    run_one("mul", 32'h0001_0001, 32'h0001_0003, OP_MUL, 4'd7);
    run_one("sra", 32'h8000_0000, 32'd4, OP_SRA, 4'd8);

    // Backpressure with a queued sub accepted on the draining edge
    drive_req(32'd20, 32'd22, OP_ADD, 4'd1);
    @(negedge clk);
    drive_req(32'd9, 32'd4, OP_SUB, 4'd2);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_r", bus.rsp_r, 32'd42);
      check("bp_tag", 32'(bus.rsp_tag), 32'd1);
      check("bp_rdy", 32'(bus.req_ready), 32'd0);
      check("bp_alu_a", bus.alu_a, 32'd20);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_rdy_drain", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("bp_b2b_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_b2b_alu_a", bus.alu_a, 32'd9);
    @(negedge clk);
    check("bp_sub_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_sub_r", bus.rsp_r, 32'd5);
    check("bp_sub_tag", 32'(bus.rsp_tag), 32'd2);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Reset mid-EXEC of a mul
    drive_req(32'd6, 32'd7, OP_MUL, 4'd9);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mrst_alu_a", bus.alu_a, 32'd0);
    check("mrst_alu_op", 32'(bus.alu_op), 32'd0);
    check("mrst_r", bus.rsp_r, 32'd5 - 32'd5);
    check("mrst_tag", 32'(bus.rsp_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    check("mrst_no_rsp", 32'(seen), 32'd0);
    run_one("mul_after_rst", 32'd6, 32'd7, OP_MUL, 4'd9);

    // Randomised mixed stream
    run_stream(8);
    run_stream(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
